// File: rtl/ifq_fetch_unit.sv
// Instruction fetch/prefetch unit: word fetch over req/ack, small in-order queue toward decode.
// Optional performance counters are enabled by defining IFQ_PERF_EN.
module ifq_fetch_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 10
) (
  input  logic          clk1,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt,
  output logic          if_valid,
  output logic [31:0]   if_ir,
  output logic [31:0]   if_npc,
  input  logic          if_ready
`ifdef IFQ_PERF_EN
  ,
  output logic [15:0]   perf_fetch_cnt,
  output logic [15:0]   perf_flush_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN, HALTED} state_t;

  state_t           state;
  logic [AW-1:0]    fetch_pc;
  logic             halt_q;
  logic [CW-1:0]    cnt;
  logic [DEPTH-1:0] q_vld;
  logic [31:0]      q_ir  [DEPTH];
  logic [31:0]      q_npc [DEPTH];

  logic          ack_c;
  logic          pop_c;
  logic          flush_c;
  logic          halting_c;
  logic          push_c;
  logic [CW-1:0] wr_idx_c;
  logic [CW-1:0] cnt_after_c;
  logic [AW-1:0] pc_inc_c;
  logic [AW-1:0] target_c;
  logic [31:0]   npc_c;

  // Per-edge events; an ack only counts against a live request.
  always_comb begin
    ack_c       = imem_ack && imem_req;
    pop_c       = q_vld[0] && if_ready;
    flush_c     = redirect && (state != HALTED);
    halting_c   = halt || halt_q;
    push_c      = ack_c && (state == WAIT) && !flush_c;
    wr_idx_c    = cnt - CW'(pop_c);
    cnt_after_c = wr_idx_c + CW'(push_c);
    pc_inc_c    = fetch_pc + AW'(1);
    npc_c       = 32'(fetch_pc) + 32'd1;
    target_c    = flush_c ? redirect_pc : fetch_pc;
  end

  // Fetch control: request issue, back-to-back streaming, redirect drain, halt.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      fetch_pc  <= '0;
      halt_q    <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      if (halt) halt_q <= 1'b1;

      if (flush_c)     fetch_pc <= redirect_pc;
      else if (push_c) fetch_pc <= pc_inc_c;

      case (state)
        FETCH: begin
          if (halting_c) begin
            state <= HALTED;
          end else if (flush_c) begin
            imem_req  <= 1'b1;
            imem_addr <= redirect_pc;
            state     <= WAIT;
          end else if (cnt < CW'(DEPTH)) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (ack_c) begin
            if (halting_c) begin
              imem_req <= 1'b0;
              state    <= HALTED;
            end else if (flush_c) begin
              imem_addr <= redirect_pc;
            end else if (cnt_after_c < CW'(DEPTH)) begin
              imem_addr <= pc_inc_c;
            end else begin
              imem_req <= 1'b0;
              state    <= FETCH;
            end
          end else if (flush_c) begin
            // Old request stays on the bus until memory answers; its data is dropped.
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (ack_c) begin
            if (halting_c) begin
              imem_req <= 1'b0;
              state    <= HALTED;
            end else begin
              imem_addr <= target_c;
              state     <= WAIT;
            end
          end
        end
        HALTED: begin
          imem_req <= 1'b0;
        end
        default: begin
          imem_req <= 1'b0;
          state    <= FETCH;
        end
      endcase
    end
  end

  // Shift queue: entry 0 is the head, so decode outputs come straight from flops.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      q_vld <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_ir[i]  <= '0;
        q_npc[i] <= '0;
      end
    end else if (flush_c) begin
      cnt   <= '0;
      q_vld <= '0;
    end else begin
      if (pop_c) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          q_ir[i]  <= q_ir[i+1];
          q_npc[i] <= q_npc[i+1];
        end
        q_vld <= q_vld >> 1;
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (push_c && (CW'(i) == wr_idx_c)) begin
          q_ir[i]  <= imem_rdata;
          q_npc[i] <= npc_c;
          q_vld[i] <= 1'b1;
        end
      end
      cnt <= cnt_after_c;
    end
  end

  assign if_valid = q_vld[0];
  assign if_ir    = q_ir[0];
  assign if_npc   = q_npc[0];

`ifdef IFQ_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (push_c && (perf_fetch_cnt != 16'hFFFF))
        perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      if (flush_c && (perf_flush_cnt != 16'hFFFF))
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifq_fetch_unit.sv
// Randomized bench for ifq_fetch_unit: memory responder plus a queue-level reference model.
module tb_ifq_fetch_unit;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 10;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          halt = 1'b0;
  logic          if_valid;
  logic [31:0]   if_ir;
  logic [31:0]   if_npc;
  logic          if_ready = 1'b0;
`ifdef IFQ_PERF_EN
  logic [15:0]   perf_fetch_cnt;
  logic [15:0]   perf_flush_cnt;
`endif

  always #5 clk1 = ~clk1;

  ifq_fetch_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .if_valid    (if_valid),
    .if_ir       (if_ir),
    .if_npc      (if_npc),
    .if_ready    (if_ready)
`ifdef IFQ_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } ent_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]   mem [1024];
  ent_t          mq [$];
  logic [AW-1:0] exp_pc;
  logic [AW-1:0] held_addr;
  bit            stale, halted_m, halt_seen, req_prev, acked_prev, chk_first, saw_1024;
  int            lat, wcnt, n_acks, n_push, n_flush;

  int            ready_pct, redir_pct, max_lat;
  bit            spur_en, halt_knob, force_redir;
  logic [AW-1:0] force_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    exp_pc     = '0;
    held_addr  = '0;
    stale      = 1'b0;
    halted_m   = 1'b0;
    halt_seen  = 1'b0;
    req_prev   = 1'b0;
    acked_prev = 1'b0;
    lat        = 0;
    wcnt       = 0;
    n_acks     = 0;
    n_push     = 0;
    n_flush    = 0;
  endtask

  // Assert reset just after a falling edge; optionally leave a late ack on the bus.
  task automatic do_reset(input bit late_ack);
    rst_n      = 1'b0;
    redirect   = 1'b0;
    halt       = 1'b0;
    if_ready   = 1'b0;
    imem_ack   = late_ack;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rst_req",   32'(imem_req),  32'd0);
    chk("rst_addr",  32'(imem_addr), 32'd0);
    chk("rst_valid", 32'(if_valid),  32'd0);
    chk("rst_ir",    if_ir,          32'd0);
    chk("rst_npc",   if_npc,         32'd0);
`ifdef IFQ_PERF_EN
    chk("rst_perf_fetch", 32'(perf_fetch_cnt), 32'd0);
    chk("rst_perf_flush", 32'(perf_flush_cnt), 32'd0);
`endif
    repeat (2) @(negedge clk1);
    model_clear();
    rst_n     = 1'b1;
    chk_first = 1'b1;
  endtask

  // One cycle: check outputs, drive memory/decode/branch inputs, advance the model.
  task automatic step();
    bit new_req, ack_e, pop_e, flush_e;
    @(negedge clk1);
    new_req = imem_req && (!req_prev || acked_prev);

    if (chk_first) begin
      chk("first_req", 32'(imem_req), 32'd1);
      chk_first = 1'b0;
    end
    chk("if_valid", 32'(if_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("if_ir",  if_ir,  mq[0].ir);
      chk("if_npc", if_npc, mq[0].npc);
    end
    if (halted_m) begin
      chk("halt_req", 32'(imem_req), 32'd0);
    end else if (new_req && !stale) begin
      chk("req_addr",  32'(imem_addr), 32'(exp_pc));
      chk("req_space", 32'(mq.size() < DEPTH), 32'd1);
    end else if (imem_req) begin
      chk("addr_hold", 32'(imem_addr), 32'(held_addr));
    end
    held_addr = imem_addr;

    // Memory responder with a random per-request latency.
    if (new_req) begin
      lat  = $urandom_range(0, max_lat);
      wcnt = 0;
    end
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (imem_req) begin
      if (wcnt == lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
      end else begin
        wcnt++;
      end
    end else if (spur_en && $urandom_range(0, 15) == 0) begin
      imem_ack = 1'b1;
    end

    if_ready    = ($urandom_range(0, 99) < ready_pct);
    redirect    = ($urandom_range(0, 99) < redir_pct);
    redirect_pc = AW'($urandom);
    if (force_redir) begin
      redirect    = 1'b1;
      redirect_pc = force_pc;
      force_redir = 1'b0;
    end
    halt      = halt_knob;
    halt_knob = 1'b0;

    // Reference model update for the coming rising edge.
    ack_e   = imem_ack && imem_req;
    pop_e   = (mq.size() != 0) && if_ready;
    flush_e = redirect && !halted_m;
    if (ack_e) n_acks++;
    if (flush_e) begin
      mq.delete();
      exp_pc = redirect_pc;
      stale  = imem_req && !ack_e;
      n_flush++;
    end else begin
      if (pop_e) begin
        if (mq[0].npc == 32'd1024) saw_1024 = 1'b1;
        void'(mq.pop_front());
      end
      if (ack_e) begin
        if (!stale) begin
          mq.push_back(ent_t'{ir: mem[exp_pc], npc: 32'(exp_pc) + 32'd1});
          exp_pc = exp_pc + AW'(1);
          n_push++;
        end
        stale = 1'b0;
      end
    end
    if ((halt || halt_seen) && (!imem_req || ack_e)) halted_m = 1'b1;
    if (halt) halt_seen = 1'b1;
    req_prev   = imem_req;
    acked_prev = ack_e;
  endtask

  initial begin
    int valid_cnt;
    bit got_req;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h2801000A;
    mem[1] = 32'h2802000B;
    mem[2] = 32'h2803000C;
    mem[3] = 32'h2804000D;
    ready_pct = 100; redir_pct = 0; max_lat = 0;
    spur_en = 1'b0; halt_knob = 1'b0; force_redir = 1'b0; force_pc = '0;
    saw_1024 = 1'b0; chk_first = 1'b0;
    model_clear();

    // Zero-wait memory, decode always ready: one instruction per cycle.
    @(negedge clk1);
    do_reset(1'b0);
    valid_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i >= 4 && if_valid) valid_cnt++;
    end
    chk("throughput", 32'(valid_cnt), 32'd16);

    // Decode stalled: queue fills with exactly DEPTH words, then one pop frees one slot.
    do_reset(1'b0);
    ready_pct = 0;
    for (int i = 0; i < 12; i++) step();
    chk("full_acks", 32'(n_acks), 32'(DEPTH));
    chk("full_noreq", 32'(imem_req), 32'd0);
    ready_pct = 100;
    step();
    ready_pct = 0;
    for (int i = 0; i < 6; i++) step();
    chk("refill_acks", 32'(n_acks), 32'(DEPTH + 1));
    chk("refill_noreq", 32'(imem_req), 32'd0);

    // Address wrap at the top of memory.
    force_redir = 1'b1;
    force_pc    = AW'(1021);
    ready_pct   = 100;
    for (int i = 0; i < 12; i++) step();
    chk("npc_1024_seen", 32'(saw_1024), 32'd1);

    // Random latency, random stalls, redirects (incl. drains) and stray acks.
    ready_pct = 70; redir_pct = 4; max_lat = 3; spur_en = 1'b1;
    n_push = 0;
    for (int i = 0; i < 4000; i++) step();
    chk("progress", 32'(n_push > 300), 32'd1);

    // Halt: outstanding work completes, queue drains, redirects ignored.
    ready_pct = 20; redir_pct = 0;
    for (int i = 0; i < 10; i++) step();
    halt_knob = 1'b1;
    step();
    ready_pct = 60; redir_pct = 10;
    for (int i = 0; i < 80; i++) step();
    chk("halt_noreq", 32'(imem_req), 32'd0);
    chk("halt_drained", 32'(if_valid), 32'd0);

`ifdef IFQ_PERF_EN
    // Counters since the last reset, against the model's event counts.
    chk("perf_fetch", 32'(perf_fetch_cnt), 32'(n_push_total()));
    chk("perf_flush", 32'(perf_flush_cnt), 32'(n_flush));
`endif

    // Reset in the middle of an outstanding request, with a late ack afterwards.
    do_reset(1'b0);
    ready_pct = 100; redir_pct = 0; max_lat = 3; spur_en = 1'b0;
    got_req = 1'b0;
    for (int i = 0; i < 20 && !got_req; i++) begin
      step();
      got_req = imem_req;
    end
    chk("req_rise", 32'(got_req), 32'd1);
    do_reset(1'b1);
    ready_pct = 70; redir_pct = 3;
    for (int i = 0; i < 200; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

`ifdef IFQ_PERF_EN
  // Pushes since the last reset: the random phase restarted n_push, so keep a separate tally.
  int push_since_rst = 0;
  always @(negedge rst_n) push_since_rst = 0;
  always @(posedge clk1) begin
    if (rst_n && imem_req && imem_ack && !redirect && !stale && !halted_m)
      push_since_rst <= push_since_rst + 1;
  end
  function automatic int n_push_total();
    return push_since_rst;
  endfunction
`endif

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

endmodule
